// File: rtl/pxs_mux_n.sv
// N-channel pixel-stream multiplexer with a registered output and an optional
// frame-synchronous switching mode that defers selection changes to the next vsync edge.
module pxs_mux_n #(
   parameter int N_CH      = 4,
   parameter int STR_W     = 26,
   parameter int VSYNC_BIT = 25,
   parameter int VSYNC_POL = 1,
   parameter int SEL_W     = 3
) (
   input  logic                    px_clk,
   input  logic                    reset_n,
   input  logic [N_CH*STR_W-1:0]   RGBStr_i,
   input  logic [SEL_W-1:0]        sel_i,
   input  logic                    frame_sync_i,
   output logic [STR_W-1:0]        RGBStr_o,
   output logic [SEL_W-1:0]        active_sel_o,
   output logic                    pending_o,
   output logic                    switch_done_o
);

   localparam int             N_SLOT = 2**SEL_W;
   localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);
   localparam logic           VS_ACT = 1'(VSYNC_POL);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t             state_reg, state_next;
   logic [SEL_W-1:0]   active_sel_reg, pending_sel_reg, pending_sel_next, sel_eff;
   logic               vs_prev_reg, vs_next, done_reg, commit_pulse;
   logic [STR_W-1:0]   data_reg;
   logic [STR_W-1:0]   ch_data [N_SLOT];
   logic               req_valid, new_req, vs_now, frame_start;

   // Slots beyond N_CH read as zero so the selector can index every code safely.
   generate
      for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_ch
         if (gi < N_CH) begin : g_used
            assign ch_data[gi] = RGBStr_i[gi*STR_W +: STR_W];
         end else begin : g_unused
            assign ch_data[gi] = '0;
         end
      end
   endgenerate

   assign req_valid   = ({1'b0, sel_i} < N_CH_L);
   assign new_req     = req_valid && (sel_i != active_sel_reg);
   assign vs_now      = ch_data[active_sel_reg][VSYNC_BIT] ~^ VS_ACT;
   assign frame_start = vs_now && !vs_prev_reg;
   // Edge history follows the channel that will be on the output after this edge.
   assign vs_next     = ch_data[sel_eff][VSYNC_BIT] ~^ VS_ACT;

   always_ff @(posedge px_clk) begin
      if (!reset_n) begin
         state_reg       <= S_IDLE;
         active_sel_reg  <= '0;
         pending_sel_reg <= '0;
         vs_prev_reg     <= 1'b0;
         data_reg        <= '0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         active_sel_reg  <= sel_eff;
         pending_sel_reg <= pending_sel_next;
         vs_prev_reg     <= vs_next;
         data_reg        <= ch_data[sel_eff];
         done_reg        <= commit_pulse;
      end
   end

   always_comb begin
      state_next       = state_reg;
      pending_sel_next = pending_sel_reg;
      sel_eff          = active_sel_reg;
      commit_pulse     = 1'b0;
      if (!frame_sync_i) begin
         // Leaving frame mode flushes any waiting request at this edge.
         state_next = S_IDLE;
         if (new_req)
            sel_eff = sel_i;
         else if (state_reg == S_WAIT)
            sel_eff = pending_sel_reg;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (new_req) begin
                  if (frame_start) begin
                     sel_eff      = sel_i;
                     commit_pulse = 1'b1;
                  end else begin
                     state_next       = S_WAIT;
                     pending_sel_next = sel_i;
                  end
               end
            end
            S_WAIT: begin
               if (frame_start) begin
                  sel_eff      = new_req ? sel_i : pending_sel_reg;
                  commit_pulse = (sel_eff != active_sel_reg);
                  state_next   = S_IDLE;
               end else if (req_valid && !new_req) begin
                  state_next = S_IDLE;
               end else if (new_req) begin
                  pending_sel_next = sel_i;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      RGBStr_o      = data_reg;
      active_sel_o  = active_sel_reg;
      pending_o     = (state_reg == S_WAIT);
      switch_done_o = done_reg;
   end

endmodule

// File: tb/tb_pxs_mux_n.sv
// Bench for pxs_mux_n: vector table plus hand sequences, expected outputs queued at drive
// time and compared one cycle later when the registered output appears.
module tb_pxs_mux_n;

   logic          px_clk = 1'b0;
   logic          reset_n;
   logic [103:0]  RGBStr_i;
   logic [2:0]    sel_i;
   logic          frame_sync_i;
   logic [25:0]   RGBStr_o;
   logic [2:0]    active_sel_o;
   logic          pending_o;
   logic          switch_done_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 px_clk = ~px_clk;

   pxs_mux_n #(.N_CH(4), .STR_W(26), .VSYNC_BIT(25), .VSYNC_POL(1), .SEL_W(3)) dut (
      .px_clk        (px_clk),
      .reset_n       (reset_n),
      .RGBStr_i      (RGBStr_i),
      .sel_i         (sel_i),
      .frame_sync_i  (frame_sync_i),
      .RGBStr_o      (RGBStr_o),
      .active_sel_o  (active_sel_o),
      .pending_o     (pending_o),
      .switch_done_o (switch_done_o)
   );

   typedef struct {
      bit         rst_n;
      bit         fs;
      logic [2:0] sel;
      logic [3:0] vs;
      logic [2:0] act;
      bit         pend;
      bit         done;
      bit         fix0;
   } vec_t;

   typedef struct {
      logic [25:0] data;
      logic [2:0]  act;
      bit          pend;
      bit          done;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[29];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL cyc=%0d %s got=%0h want=%0h", cyc, name, got, want);
      end
   endtask

   task automatic drive_cycle(input bit rst_n, input bit fs, input logic [2:0] sel,
                              input logic [3:0] vs, input logic [2:0] act,
                              input bit pend, input bit done, input bit fix0);
      logic [25:0] w [4];
      exp_t e, g;
      for (int k = 0; k < 4; k++) w[k] = {vs[k], 3'(k), 22'($urandom)};
      if (fix0) w[0] = 26'h0ABCDEF;
      reset_n      = rst_n;
      frame_sync_i = fs;
      sel_i        = sel;
      RGBStr_i     = {w[3], w[2], w[1], w[0]};
      e.data = rst_n ? w[act[1:0]] : 26'h0;
      e.act  = act;
      e.pend = pend;
      e.done = done;
      exp_q.push_back(e);
      @(posedge px_clk);
      #1;
      cyc++;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("[TB] FAIL cyc=%0d scoreboard_empty got=0 want=1", cyc);
      end else begin
         n_tests--;
         g = exp_q.pop_front();
         chk("data", 32'(RGBStr_o), 32'(g.data));
         chk("active_sel", 32'(active_sel_o), 32'(g.act));
         chk("pending", 32'(pending_o), 32'(g.pend));
         chk("switch_done", 32'(switch_done_o), 32'(g.done));
      end
      $display("[TB] cyc=%0d rst_n=%0b fs=%0b sel=%0d vs=%b -> act=%0d pend=%0b done=%0b data=%07h",
               cyc, rst_n, fs, sel, vs, active_sel_o, pending_o, switch_done_o, RGBStr_o);
   endtask

   initial begin
      //          rst fs sel   vs       act  pend done fix0
      vecs[0]  = '{0, 0, 3'd2, 4'b0000, 3'd0, 0, 0, 0};
      vecs[1]  = '{0, 1, 3'd3, 4'b1111, 3'd0, 0, 0, 0};
      vecs[2]  = '{1, 0, 3'd0, 4'b0000, 3'd0, 0, 0, 1};
      vecs[3]  = '{1, 0, 3'd2, 4'b0000, 3'd2, 0, 0, 0};
      vecs[4]  = '{1, 0, 3'd2, 4'b0000, 3'd2, 0, 0, 0};
      vecs[5]  = '{1, 0, 3'd5, 4'b0000, 3'd2, 0, 0, 0};
      vecs[6]  = '{1, 1, 3'd7, 4'b0000, 3'd2, 0, 0, 0};
      vecs[7]  = '{1, 0, 3'd0, 4'b0000, 3'd0, 0, 0, 0};
      vecs[8]  = '{1, 1, 3'd3, 4'b0000, 3'd0, 1, 0, 0};
      vecs[9]  = '{1, 1, 3'd3, 4'b0000, 3'd0, 1, 0, 0};
      vecs[10] = '{1, 1, 3'd5, 4'b0000, 3'd0, 1, 0, 0};
      vecs[11] = '{1, 1, 3'd3, 4'b1000, 3'd0, 1, 0, 0};
      vecs[12] = '{1, 1, 3'd4, 4'b0001, 3'd3, 0, 1, 0};
      vecs[13] = '{1, 1, 3'd4, 4'b0001, 3'd3, 0, 0, 0};
      vecs[14] = '{1, 1, 3'd1, 4'b0000, 3'd3, 1, 0, 0};
      vecs[15] = '{1, 1, 3'd2, 4'b0000, 3'd3, 1, 0, 0};
      vecs[16] = '{1, 1, 3'd1, 4'b0000, 3'd3, 1, 0, 0};
      vecs[17] = '{1, 1, 3'd5, 4'b1000, 3'd1, 0, 1, 0};
      vecs[18] = '{1, 1, 3'd2, 4'b0000, 3'd1, 1, 0, 0};
      vecs[19] = '{1, 1, 3'd1, 4'b0000, 3'd1, 0, 0, 0};
      vecs[20] = '{1, 1, 3'd5, 4'b0010, 3'd1, 0, 0, 0};
      vecs[21] = '{1, 1, 3'd5, 4'b0000, 3'd1, 0, 0, 0};
      vecs[22] = '{1, 1, 3'd0, 4'b0010, 3'd0, 0, 1, 0};
      vecs[23] = '{1, 1, 3'd2, 4'b0100, 3'd0, 1, 0, 0};
      vecs[24] = '{1, 1, 3'd2, 4'b0001, 3'd2, 0, 1, 0};
      vecs[25] = '{1, 1, 3'd3, 4'b0000, 3'd2, 1, 0, 0};
      vecs[26] = '{1, 1, 3'd5, 4'b0000, 3'd2, 1, 0, 0};
      vecs[27] = '{1, 0, 3'd5, 4'b0000, 3'd3, 0, 0, 0};
      vecs[28] = '{1, 0, 3'd6, 4'b0000, 3'd3, 0, 0, 0};

      reset_n = 1'b0; frame_sync_i = 1'b0; sel_i = '0; RGBStr_i = '0;
      #1;

      foreach (vecs[i])
         drive_cycle(vecs[i].rst_n, vecs[i].fs, vecs[i].sel, vecs[i].vs,
                     vecs[i].act, vecs[i].pend, vecs[i].done, vecs[i].fix0);

      // Reset while a deferred switch is waiting: nothing survives it.
      drive_cycle(1, 0, 3'd0, 4'b0000, 3'd0, 0, 0, 0);
      drive_cycle(1, 1, 3'd2, 4'b0000, 3'd0, 1, 0, 0);
      drive_cycle(0, 1, 3'd2, 4'b0000, 3'd0, 0, 0, 0);
      drive_cycle(1, 1, 3'd0, 4'b0000, 3'd0, 0, 0, 0);
      drive_cycle(1, 1, 3'd5, 4'b0001, 3'd0, 0, 0, 0);
      drive_cycle(1, 1, 3'd5, 4'b0000, 3'd0, 0, 0, 0);

      // Active channel never shows vsync: the request waits and the output stays on ch0.
      for (int i = 0; i < 40; i++)
         drive_cycle(1, 1, 3'd1, {3'($urandom), 1'b0}, 3'd0, 1, 0, 0);
      drive_cycle(1, 1, 3'd0, 4'b0000, 3'd0, 0, 0, 0);

      // Out-of-range selectors in either mode never move the mux.
      for (int i = 0; i < 100; i++)
         drive_cycle(1, 1'($urandom), 3'($urandom_range(7, 4)), 4'($urandom), 3'd0, 0, 0, 0);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
